// File: rtl/sha2_msg_scheduler.sv
// SHA-2 message schedule generator (SHA-256 / SHA-512) built on a 16-word rolling window.
// Accepts one padded block and streams W[0..ROUNDS-1] over a valid/ready handshake.
module sha2_msg_scheduler #(
  parameter int unsigned WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  block_valid,
  output logic                  block_ready,
  input  logic [16*WORD_W-1:0]  block_in,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_out,
  output logic [6:0]            w_idx,
  output logic                  w_last
);

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned WIN_N  = 16;
  localparam int unsigned ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam int unsigned S0_A   = (WORD_W == 64) ? 1  : 7;
  localparam int unsigned S0_B   = (WORD_W == 64) ? 8  : 18;
  localparam int unsigned S0_S   = (WORD_W == 64) ? 7  : 3;
  localparam int unsigned S1_A   = (WORD_W == 64) ? 19 : 17;
  localparam int unsigned S1_B   = (WORD_W == 64) ? 61 : 19;
  localparam int unsigned S1_S   = (WORD_W == 64) ? 6  : 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_msg_scheduler: WORD_W must be 32 or 64");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [WIN_N-1:0][WORD_W-1:0]  win_q;
  logic [IDX_W-1:0]              idx_q;
  logic                          last_q;
  logic [WORD_W-1:0]             new_word;
  logic                          hs, last_hs, accept;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);
  endfunction

  // Window holds W[idx..idx+15]; the word entering at the top is W[idx+16].
  assign new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  assign w_valid     = (state_q == RUN);
  assign w_out       = win_q[0];
  assign w_idx       = idx_q;
  assign w_last      = last_q;
  assign hs          = w_valid & w_ready;
  assign last_hs     = hs & w_last;
  assign block_ready = (state_q == IDLE) | last_hs;
  assign accept      = block_valid & block_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (block_valid) state_d = RUN;
      RUN:     if (last_hs && !block_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window is zeroed when going idle so w_out reads 0 outside RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q  <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < 16; k++) begin
        win_q[k] <= block_in[(16-k)*WORD_W-1 -: WORD_W];
      end
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (last_hs) begin
      win_q  <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (hs) begin
      for (int k = 0; k < 15; k++) begin
        win_q[k] <= win_q[k+1];
      end
      win_q[15] <= new_word;
      idx_q     <= idx_q + IDX_W'(1);
      last_q    <= ((idx_q + IDX_W'(1)) == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_sha2_msg_scheduler.sv
// Bench for sha2_msg_scheduler: SHA-256 and SHA-512 instances against an array-based schedule model.
module tb_sha2_msg_scheduler;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          bv;
  logic          wr;
  bit            sel;
  logic [511:0]  blk32;
  logic [1023:0] blk64;
  logic          bv32, bv64;
  logic          br32, br64, wv32, wv64, wl32, wl64;
  logic [31:0]   wo32;
  logic [63:0]   wo64;
  logic [6:0]    wi32, wi64;
  logic          br, wv, wl;
  logic [63:0]   wo;
  logic [6:0]    wi;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          ww;
    int          t;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  assign bv32 = bv & ~sel;
  assign bv64 = bv & sel;
  assign br = sel ? br64 : br32;
  assign wv = sel ? wv64 : wv32;
  assign wl = sel ? wl64 : wl32;
  assign wo = sel ? wo64 : {32'h0, wo32};
  assign wi = sel ? wi64 : wi32;

  sha2_msg_scheduler #(.WORD_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .block_valid(bv32), .block_ready(br32), .block_in(blk32),
    .w_valid(wv32), .w_ready(wr), .w_out(wo32), .w_idx(wi32), .w_last(wl32));

  sha2_msg_scheduler #(.WORD_W(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .block_valid(bv64), .block_ready(br64), .block_in(blk64),
    .w_valid(wv64), .w_ready(wr), .w_out(wo64), .w_idx(wi64), .w_last(wl64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] msk(input int ww);
    return (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int ww);
    logic [63:0] y;
    y = x & msk(ww);
    return ((y >> n) | (y << (ww - n))) & msk(ww);
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input int ww);
    logic [63:0] y;
    y = x & msk(ww);
    if (ww == 32) return rr(y, 7, ww) ^ rr(y, 18, ww) ^ (y >> 3);
    return rr(y, 1, ww) ^ rr(y, 8, ww) ^ (y >> 7);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input int ww);
    logic [63:0] y;
    y = x & msk(ww);
    if (ww == 32) return rr(y, 17, ww) ^ rr(y, 19, ww) ^ (y >> 10);
    return rr(y, 19, ww) ^ rr(y, 61, ww) ^ (y >> 6);
  endfunction

  // Full-length FIPS schedule, computed directly from the recurrence.
  task automatic model(input int ww, input logic [63:0] b[16], output logic [63:0] w[80]);
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = b[t] & msk(ww);
      else w[t] = (s1(w[t-2], ww) + w[t-7] + s0(w[t-15], ww) + w[t-16]) & msk(ww);
    end
  endtask

  task automatic load_blk(input int ww, input logic [63:0] b[16]);
    for (int k = 0; k < 16; k++) begin
      if (ww == 32) blk32[(16-k)*32-1 -: 32] = b[k][31:0];
      else          blk64[(16-k)*64-1 -: 64] = b[k];
    end
  endtask

  task automatic send(input int ww, input logic [63:0] b[16], input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    load_blk(ww, b);
    bv = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (br) ok = 1'b1;
      @(posedge clk);
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    #1;
    if (!keep) bv = 1'b0;
  endtask

  task automatic stream(input int ww, input bit rnd, input int bv_lo, input int bv_hi,
                        output logic [63:0] got[80], output int n);
    int          rounds;
    bit          stall_prev;
    logic [63:0] pw;
    logic [6:0]  pi;
    rounds = (ww == 64) ? 80 : 64;
    stall_prev = 1'b0;
    pw = '0;
    pi = '0;
    n = 0;
    for (int t = 0; t < 80; t++) got[t] = '0;
    for (int c = 0; c < 2000 && n < rounds; c++) begin
      @(negedge clk);
      wr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bv_lo >= 0) bv = (n >= bv_lo && n < bv_hi);
      #1;
      check("w_valid_in_run", 64'(wv), 64'd1);
      if (stall_prev) begin
        check("stall_w_out", wo, pw);
        check("stall_w_idx", 64'(wi), 64'(pi));
      end
      check("block_ready_in_run", 64'(br), 64'(wr & wl));
      if (wr) begin
        check("w_idx", 64'(wi), 64'(n));
        check("w_last", 64'(wl), 64'(n == rounds - 1));
        got[n] = wo;
        n++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        pw = wo;
        pi = wi;
      end
    end
    if (n < rounds) check("stream_timeout", 64'(n), 64'(rounds));
  endtask

  task automatic verify(input string tag, input int ww, input logic [63:0] b[16], input logic [63:0] got[80]);
    logic [63:0] w[80];
    model(ww, b, w);
    for (int t = 0; t < ((ww == 64) ? 80 : 64); t++)
      check($sformatf("%s W[%0d]", tag, t), got[t], w[t]);
  endtask

  task automatic idle_check(input string tag);
    check({tag, " w_valid"}, 64'(wv), 64'd0);
    check({tag, " w_out"}, wo, 64'd0);
    check({tag, " w_idx"}, 64'(wi), 64'd0);
    check({tag, " w_last"}, 64'(wl), 64'd0);
    check({tag, " block_ready"}, 64'(br), 64'd1);
  endtask

  task automatic rand_blk(output logic [63:0] b[16]);
    for (int k = 0; k < 16; k++) b[k] = {$urandom, $urandom};
  endtask

  task automatic one_block(input string tag, input int ww, input logic [63:0] b[16], input bit rnd,
                           output logic [63:0] got[80]);
    int n;
    sel = (ww == 64);
    send(ww, b, 1'b0);
    stream(ww, rnd, -1, -1, got, n);
    verify(tag, ww, b, got);
    @(posedge clk);
    #1;
    idle_check({tag, " end"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] abc32[16], abc64[16], b1[16], b2[16];
    logic [63:0] g[80], g2[80];
    int n;
    bit hit;

    vecs[0] = '{32, 0,  64'h0000_0000_6162_6380};
    vecs[1] = '{32, 16, 64'h0000_0000_6162_6380};
    vecs[2] = '{32, 17, 64'h0000_0000_000F_0000};
    vecs[3] = '{32, 63, 64'h0000_0000_12B1_EDEB};
    vecs[4] = '{64, 0,  64'h6162_6380_0000_0000};
    vecs[5] = '{64, 16, 64'h6162_6380_0000_0000};
    vecs[6] = '{64, 17, 64'h0003_0000_0000_00C0};

    for (int k = 0; k < 16; k++) begin
      abc32[k] = '0;
      abc64[k] = '0;
    end
    abc32[0] = 64'h6162_6380;
    abc32[15] = 64'h18;
    abc64[0] = 64'h6162_6380_0000_0000;
    abc64[15] = 64'h18;

    reset_n = 1'b0;
    bv = 1'b0;
    wr = 1'b0;
    sel = 1'b0;
    blk32 = '0;
    blk64 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset w_valid", 64'(wv), 64'd0);
    check("reset w_out", wo, 64'd0);
    check("reset w_idx", 64'(wi), 64'd0);
    check("reset w_last", 64'(wl), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post-reset block_ready", 64'(br), 64'd1);

    // Known-answer "abc" blocks with the table of spot values.
    one_block("abc256", 32, abc32, 1'b0, g);
    one_block("abc512", 64, abc64, 1'b0, g2);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ww == 32) check($sformatf("kat256 W[%0d]", vecs[i].t), g[vecs[i].t], vecs[i].exp);
      else                  check($sformatf("kat512 W[%0d]", vecs[i].t), g2[vecs[i].t], vecs[i].exp);
    end

    // Random backpressure on the same blocks.
    one_block("abc256_stall", 32, abc32, 1'b1, g);
    one_block("abc512_stall", 64, abc64, 1'b1, g);

    // Back-to-back blocks with block_valid held high.
    sel = 1'b0;
    rand_blk(b1);
    rand_blk(b2);
    send(32, b1, 1'b1);
    load_blk(32, b2);
    stream(32, 1'b0, -1, -1, g, n);
    @(posedge clk);
    #1;
    bv = 1'b0;
    stream(32, 1'b0, -1, -1, g2, n);
    verify("b2b_first", 32, b1, g);
    verify("b2b_second", 32, b2, g2);
    @(posedge clk);
    #1;
    idle_check("b2b end");

    // Asynchronous reset in the middle of a block.
    sel = 1'b0;
    send(32, abc32, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      wr = 1'b1;
      #1;
      if (wi == 7'd20) hit = 1'b1;
    end
    check("reached_idx20", 64'(hit), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset w_valid", 64'(wv), 64'd0);
    check("async_reset w_out", wo, 64'd0);
    check("async_reset w_idx", 64'(wi), 64'd0);
    check("async_reset w_last", 64'(wl), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("after_reset block_ready", 64'(br), 64'd1);
    check("after_reset w_valid", 64'(wv), 64'd0);
    rand_blk(b1);
    one_block("post_reset", 32, b1, 1'b0, g);

    // block_valid raised mid-block must be ignored.
    sel = 1'b0;
    rand_blk(b2);
    send(32, abc32, 1'b0);
    load_blk(32, b2);
    stream(32, 1'b0, 30, 36, g, n);
    verify("midblock_bv", 32, abc32, g);
    @(posedge clk);
    #1;
    idle_check("midblock_bv end");

    // Random blocks with random backpressure for both widths.
    for (int r = 0; r < 3; r++) begin
      rand_blk(b1);
      one_block($sformatf("rand256_%0d", r), 32, b1, 1'b1, g);
      rand_blk(b1);
      one_block($sformatf("rand512_%0d", r), 64, b1, 1'b1, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
